cada_addr_stream_gen: RTL and testbench

- Responder end of the CADA memory-lane descriptor interface: the valid / writeEn / startAddr / count / stride pulses that the wrapper's port group receives.
- Accepts fire-and-forget access descriptors and expands each one into a cycle-by-cycle stream of memory addresses, read/write enables and aligned write data for a single memory lane.
- Holds up to two pending descriptors behind the active one, so back-to-back bursts run without bubbles.
- One instance sits per port (port 1 / port 2) in front of each lane's SRAM.

---
 rtl/cada_addr_stream_gen.sv | 203 ++++++++++++++++++++
 tb/tb_cada_addr_stream_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cada_addr_stream_gen.sv
// cada_addr_stream_gen: expands access descriptors into a per-cycle stream of
// memory addresses, read/write enables and aligned write data for one lane.
// One burst is active; up to two more wait in a small FIFO so that successive
// bursts issue back to back.
module cada_addr_stream_gen #(
  parameter int ADDR_W   = 6,
  parameter int CNT_W    = 7,
  parameter int STRIDE_W = 1,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                validIn,
  input  logic                writeEnIn,
  input  logic [ADDR_W-1:0]   addrIn,
  input  logic [STRIDE_W-1:0] strideIn,
  input  logic [CNT_W-1:0]    countIn,
  input  logic [DATA_W-1:0]   dataIn,
  output logic [ADDR_W-1:0]   memAddr,
  output logic                memWEn,
  output logic                memREn,
  output logic [DATA_W-1:0]   memWData,
  output logic                rdValid,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [STRIDE_W-1:0] stride;
    logic [CNT_W-1:0]    cnt;
  } desc_t;

  state_t              state_q, state_d;
  desc_t [1:0]         fifo_q, fifo_d;
  logic [1:0]          fcnt_q, fcnt_d;
  // next_q is the address of the next access to issue in RUN
  logic [ADDR_W-1:0]   next_q, next_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wen_q, mem_wen_d;
  logic                mem_ren_q, mem_ren_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  desc_t               in_desc, ld;
  logic                fifo_ne, avail, take, handoff, issue, issue_wr;
  logic                pop, bypass, push;
  logic [ADDR_W-1:0]   issue_addr;

  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a,
                                             input logic [STRIDE_W-1:0] s);
    return a + ADDR_W'(s);
  endfunction

  // Next-state: descriptor selection, access issue, FIFO push/pop, outputs
  always_comb begin
    in_desc     = '{we: writeEnIn, addr: addrIn, stride: strideIn, cnt: countIn};
    fifo_ne     = (fcnt_q != 2'd0);
    avail       = fifo_ne | validIn;
    // queued work always wins over a fresh descriptor
    ld          = fifo_ne ? fifo_q[0] : in_desc;
    state_d     = state_q;
    next_d      = next_q;
    stride_d    = stride_q;
    rem_d       = rem_q;
    wr_d        = wr_q;
    take        = 1'b0;
    handoff     = 1'b0;
    issue       = 1'b0;
    issue_wr    = 1'b0;
    issue_addr  = next_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail) begin
          take     = 1'b1;
          stride_d = ld.stride;
          wr_d     = ld.we;
          if (ld.cnt != '0) begin
            issue      = 1'b1;
            issue_wr   = ld.we;
            issue_addr = ld.addr;
            next_d     = step(ld.addr, ld.stride);
            rem_d      = ld.cnt - CNT_W'(1);
            done_d     = (ld.cnt == CNT_W'(1));
            state_d    = (ld.cnt == CNT_W'(1)) ? IDLE : RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (rem_q == '0) begin
          // empty burst handed over from a previous one: report and move on
          done_d  = 1'b1;
          handoff = 1'b1;
        end else begin
          issue    = 1'b1;
          issue_wr = wr_q;
          next_d   = step(next_q, stride_q);
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            handoff = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // chain into the next descriptor; its first access issues next edge
    if (handoff) begin
      if (avail) begin
        take     = 1'b1;
        next_d   = ld.addr;
        stride_d = ld.stride;
        rem_d    = ld.cnt;
        wr_d     = ld.we;
        state_d  = RUN;
      end else begin
        state_d  = IDLE;
      end
    end

    pop    = take & fifo_ne;
    bypass = take & ~fifo_ne;
    push   = validIn & ~bypass;
    fifo_d = fifo_q;
    fcnt_d = fcnt_q;
    ovf_d  = ovf_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fcnt_d    = fcnt_q - 2'd1;
    end
    if (push) begin
      if (fcnt_d != 2'd2) begin
        fifo_d[fcnt_d[0]] = in_desc;
        fcnt_d            = fcnt_d + 2'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    mem_addr_d  = issue ? issue_addr : mem_addr_q;
    mem_wen_d   = issue & issue_wr;
    mem_ren_d   = issue & ~issue_wr;
    mem_wdata_d = (issue & issue_wr) ? dataIn : mem_wdata_q;
    rd_valid_d  = mem_ren_q;
  end

  // FSM, descriptor storage and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fifo_q      <= '0;
      fcnt_q      <= '0;
      next_q      <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      fcnt_q      <= fcnt_d;
      next_q      <= next_d;
      stride_q    <= stride_d;
      rem_q       <= rem_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
      mem_wdata_q <= mem_wdata_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign memAddr  = mem_addr_q;
  assign memWEn   = mem_wen_q;
  assign memREn   = mem_ren_q;
  assign memWData = mem_wdata_q;
  assign rdValid  = rd_valid_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == RUN) | (fcnt_q != 2'd0);

endmodule

// File: tb/tb_cada_addr_stream_gen.sv
// Bench for cada_addr_stream_gen: directed scenarios plus randomized bursts
// checked against an access-list model built from descriptor arithmetic.
module tb_cada_addr_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validIn = 1'b0, writeEnIn = 1'b0;
  logic [5:0]  addrIn = '0;
  logic [0:0]  strideIn = '0;
  logic [6:0]  countIn = '0;
  logic [15:0] dataIn = '0;
  logic [5:0]  memAddr;
  logic        memWEn, memREn, rdValid, busy, done, ovf;
  logic [15:0] memWData;

  int checks = 0, failures = 0;

  cada_addr_stream_gen dut (
    .clk(clk), .rst(rst), .validIn(validIn), .writeEnIn(writeEnIn),
    .addrIn(addrIn), .strideIn(strideIn), .countIn(countIn), .dataIn(dataIn),
    .memAddr(memAddr), .memWEn(memWEn), .memREn(memREn), .memWData(memWData),
    .rdValid(rdValid), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // expected access stream for the randomized test
  typedef struct { logic [5:0] a; logic we; } acc_t;
  acc_t        expq[$];
  int          exp_done = 0, obs_done = 0;
  logic        mon_en = 1'b0, rnd_data = 1'b0;
  logic [15:0] din_prev;

  always @(posedge clk) din_prev <= dataIn;

  // monitor: every observed access must be the next one the model predicts
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (done) obs_done++;
      if (memWEn || memREn) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra_access addr=%0d we=%0b expected no access", memAddr, memWEn);
        end else begin
          acc_t e;
          e = expq.pop_front();
          if (memAddr !== e.a || memWEn !== e.we || memREn !== !e.we) begin
            failures++;
            $display("FAIL rnd_access got addr=%0d we=%0b re=%0b expected addr=%0d we=%0b",
                     memAddr, memWEn, memREn, e.a, e.we);
          end
          if (memWEn && memWData !== din_prev) begin
            failures++;
            $display("FAIL rnd_wdata got %0h expected %0h", memWData, din_prev);
          end
        end
      end
    end
  end

  task automatic tick;
    if (rnd_data) dataIn = 16'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic we, input logic [5:0] a, input logic s, input logic [6:0] c);
    validIn = 1'b1; writeEnIn = we; addrIn = a; strideIn = s; countIn = c;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    checks++;
    if ({memAddr, memWEn, memREn, memWData, rdValid, busy, done, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%0d we=%0b re=%0b wd=%0h rv=%0b busy=%0b done=%0b ovf=%0b expected all 0",
               memAddr, memWEn, memREn, memWData, rdValid, busy, done, ovf);
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_bypass_write;
    logic [5:0] ea;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_desc(1'b1, 6'd0, 1'b1, 7'd3); else validIn = 1'b0;
      dataIn = 16'(i + 1);
      tick;
      ea = 6'(i);
      checks++;
      if (memWEn !== 1'b1 || memREn !== 1'b0 || memAddr !== ea || memWData !== 16'(i + 1) || done !== (i == 2)) begin
        failures++;
        $display("FAIL bypass_write_%0d got we=%0b re=%0b addr=%0d wd=%0d done=%0b expected we=1 re=0 addr=%0d wd=%0d done=%0b",
                 i, memWEn, memREn, memAddr, memWData, done, ea, i + 1, i == 2);
      end
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bypass_busy got %0b expected 0", busy); end
    tick;
    checks++;
    if (memWEn !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL bypass_after got we=%0b done=%0b expected 0 0", memWEn, done);
    end
  endtask

  task automatic test_read_wrap;
    logic [5:0] ea;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_desc(1'b0, 6'd62, 1'b1, 7'd4); else validIn = 1'b0;
      tick;
      ea = 6'((62 + i) % 64);
      checks++;
      if (memREn !== (i < 4) || memWEn !== 1'b0 || rdValid !== (i >= 1 && i < 5) ||
          (i < 4 && memAddr !== ea)) begin
        failures++;
        $display("FAIL read_wrap_%0d got re=%0b we=%0b rv=%0b addr=%0d expected re=%0b we=0 rv=%0b addr=%0d",
                 i, memREn, memWEn, rdValid, memAddr, i < 4, i >= 1 && i < 5, ea);
      end
    end
  endtask

  task automatic test_queueing;
    int n_acc = 0, n_done = 0, first = -1, last = -1;
    logic [5:0] ea;
    for (int t = 0; t < 25; t++) begin
      if (t < 4) set_desc(1'b0, 6'(t * 10), 1'b1, 7'd5); else validIn = 1'b0;
      tick;
      if (memREn) begin
        ea = 6'((n_acc / 5) * 10 + n_acc % 5);
        checks++;
        if (memAddr !== ea) begin
          failures++; $display("FAIL queue_addr_%0d got %0d expected %0d", n_acc, memAddr, ea);
        end
        if (first < 0) first = t;
        last = t;
        n_acc++;
      end
      if (done) n_done++;
      if (t == 3) begin
        checks++;
        if (ovf !== 1'b1) begin failures++; $display("FAIL queue_ovf_set got %0b expected 1", ovf); end
      end
    end
    checks++;
    if (n_acc != 15 || n_done != 3 || last - first + 1 != 15) begin
      failures++;
      $display("FAIL queue_totals got acc=%0d done=%0d span=%0d expected 15 3 15", n_acc, n_done, last - first + 1);
    end
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL queue_end got ovf=%0b busy=%0b expected 1 0", ovf, busy);
    end
  endtask

  task automatic test_edge_counts;
    set_desc(1'b1, 6'd3, 1'b1, 7'd0);
    tick;
    validIn = 1'b0;
    checks++;
    if (done !== 1'b1 || memWEn !== 1'b0 || memREn !== 1'b0) begin
      failures++; $display("FAIL count0 got done=%0b we=%0b re=%0b expected 1 0 0", done, memWEn, memREn);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL count0_after got done=%0b busy=%0b expected 0 0", done, busy);
    end
    set_desc(1'b0, 6'd9, 1'b0, 7'd1);
    tick;
    validIn = 1'b0;
    checks++;
    if (done !== 1'b1 || memREn !== 1'b1 || memAddr !== 6'd9) begin
      failures++; $display("FAIL count1 got done=%0b re=%0b addr=%0d expected 1 1 9", done, memREn, memAddr);
    end
    tick;
    checks++;
    if (done !== 1'b0 || memREn !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL count1_after got done=%0b re=%0b busy=%0b expected 0 0 0", done, memREn, busy);
    end
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_desc(1'b1, 6'd40, 1'b1, 7'd10); else validIn = 1'b0;
      dataIn = 16'hA000 + 16'(i);
      tick;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({memAddr, memWEn, memREn, memWData, rdValid, busy, done, ovf} !== '0) begin
      failures++;
      $display("FAIL reset_mid got addr=%0d we=%0b re=%0b wd=%0h rv=%0b busy=%0b done=%0b ovf=%0b expected all 0",
               memAddr, memWEn, memREn, memWData, rdValid, busy, done, ovf);
    end
    tick;
    rst = 1'b1;
    set_desc(1'b1, 6'd5, 1'b1, 7'd1);
    dataIn = 16'h1234;
    tick;
    validIn = 1'b0;
    checks++;
    if (memWEn !== 1'b1 || memAddr !== 6'd5 || memWData !== 16'h1234 || done !== 1'b1) begin
      failures++;
      $display("FAIL reset_rebypass got we=%0b addr=%0d wd=%0h done=%0b expected 1 5 1234 1", memWEn, memAddr, memWData, done);
    end
    tick;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin tick; n++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s timeout got busy=1 expected 0", tag);
    end
  endtask

  task automatic test_random_bursts;
    int k;
    logic we, s;
    logic [5:0] a;
    logic [6:0] c;
    acc_t e;
    rnd_data = 1'b1;
    mon_en   = 1'b1;
    for (int r = 0; r < 40; r++) begin
      wait_idle("rnd_wait");
      repeat ($urandom_range(0, 2)) tick;
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        we = 1'($urandom); s = 1'($urandom);
        a  = 6'($urandom); c = 7'($urandom_range(0, 6));
        for (int i = 0; i < int'(c); i++) begin
          e.a = 6'((int'(a) + i * int'(s)) % 64);
          e.we = we;
          expq.push_back(e);
        end
        exp_done++;
        set_desc(we, a, s, c);
        tick;
      end
      validIn = 1'b0;
    end
    wait_idle("rnd_drain");
    tick; tick;
    mon_en   = 1'b0;
    rnd_data = 1'b0;
    checks++;
    if (expq.size() != 0 || obs_done != exp_done) begin
      failures++;
      $display("FAIL rnd_totals got pending=%0d done=%0d expected pending=0 done=%0d", expq.size(), obs_done, exp_done);
    end
  endtask

  initial begin
    test_reset;
    test_bypass_write;
    test_read_wrap;
    test_queueing;
    test_edge_counts;
    test_reset_mid_burst;
    test_random_bursts;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
